// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised multi-read, single-write register file for
// the pipeline. Register 0 reads as zero. A per-register pending-write
// scoreboard lets decode detect RAW hazards against in-flight writebacks.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-first forwarding from the writeback port to every read port
//   undefined -> reads return stored contents only
module regfile_multiport #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    input  logic                  flush,
    output logic [AW:0]           pending_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;
    logic [AW:0]      pending_cnt_nxt;
    logic             wr_hit;
    logic             iss_hit;

    // Population count of a pending vector, used for the registered count.
    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] vec);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + (AW+1)'(vec[i]);
        end
        return cnt;
    endfunction

    // Qualified write and issue strobes; address 0 never participates.
    always_comb begin
        wr_hit  = we && (waddr != '0);
        iss_hit = issue_valid && (issue_rd != '0);
    end

    // Storage array: cleared by reset, written on the rising edge; r0 stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_hit) begin
            regs[waddr] <= wdata;
        end
    end

    // Next pending vector: flush, then writeback clear, then issue set (set wins).
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end
        if (wr_hit) begin
            pending_nxt[waddr] = 1'b0;
        end
        if (iss_hit) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
        pending_cnt_nxt = popcount(pending_nxt);
    end

    // Scoreboard and its count update together so the count always matches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= pending_cnt_nxt;
        end
    end

    // Per-port combinational read path.
    genvar p;
    generate
        for (p = 0; p < NREAD; p++) begin : g_read
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rd;
            logic            rb;

            assign ra = raddr[p*AW +: AW];

            // Read mux with zero register, optional forwarding and reset gating.
            always_comb begin
                rd = '0;
                rb = 1'b0;
                if (rst_n && (ra != '0)) begin
                    rd = regs[ra];
                    rb = pending[ra];
`ifdef REGFILE_BYPASS_EN
                    if (wr_hit && (ra == waddr)) begin
                        rd = wdata;
                        if (!(iss_hit && (issue_rd == waddr))) begin
                            rb = 1'b0;
                        end
                    end
`endif
                end
            end

            assign rdata[p*XLEN +: XLEN] = rd;
            assign rbusy[p]              = rb;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed vectors with hand-computed expectations for
// regfile_multiport (default parameters: XLEN=32, NREGS=32, NREAD=2).
module tb_regfile_multiport;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk;
    logic                  rst_n;
    logic [NREAD*AW-1:0]   raddr;
    logic [NREAD*XLEN-1:0] rdata;
    logic [NREAD-1:0]      rbusy;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [XLEN-1:0]       wdata;
    logic                  issue_valid;
    logic [AW-1:0]         issue_rd;
    logic                  flush;
    logic [AW:0]           pending_cnt;

    int num_checks;
    int num_fails;

    regfile_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one edge's worth of write/issue/flush, clock it, then return to idle.
    task automatic applyStimulus(input logic w, input logic [AW-1:0] wa,
                                 input logic [XLEN-1:0] wd, input logic iv,
                                 input logic [AW-1:0] ird, input logic fl);
        we          = w;
        waddr       = wa;
        wdata       = wd;
        issue_valid = iv;
        issue_rd    = ird;
        flush       = fl;
        @(posedge clk);
        #1;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        flush       = 1'b0;
        #1;
    endtask

    // Point both read ports at addresses and let the combinational path settle.
    task automatic setRead(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    initial begin
        num_checks  = 0;
        num_fails   = 0;
        rst_n       = 1'b0;
        raddr       = '0;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        flush       = 1'b0;

        // Reset state.
        #12;
        checkOutput("reset_cnt", 64'(pending_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int a = 0; a < NREGS; a++) begin
            setRead(AW'(a), AW'(NREGS - 1 - a));
            checkOutput("reset_rdata0", 64'(rdata[0 +: XLEN]), 64'd0);
            checkOutput("reset_rdata1", 64'(rdata[XLEN +: XLEN]), 64'd0);
            checkOutput("reset_rbusy", 64'(rbusy), 64'd0);
        end
        checkOutput("reset_cnt_after", 64'(pending_cnt), 64'd0);

        // Write r5, attempt write to r0.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0);
        setRead(5'd5, 5'd0);
        checkOutput("r5_data", 64'(rdata[0 +: XLEN]), 64'hDEADBEEF);
        checkOutput("r0_data", 64'(rdata[XLEN +: XLEN]), 64'h0);
        setRead(5'd5, 5'd5);
        checkOutput("same_addr_p0", 64'(rdata[0 +: XLEN]), 64'hDEADBEEF);
        checkOutput("same_addr_p1", 64'(rdata[XLEN +: XLEN]), 64'hDEADBEEF);

        // Same-cycle write to r6 observed on port 1 before and after the edge.
        setRead(5'd5, 5'd6);
        we    = 1'b1;
        waddr = 5'd6;
        wdata = 32'h0000CAFE;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("bypass_pre_edge", 64'(rdata[XLEN +: XLEN]), 64'h0000CAFE);
`else
        checkOutput("nobypass_pre_edge", 64'(rdata[XLEN +: XLEN]), 64'h0);
`endif
        checkOutput("pre_edge_rbusy1", 64'(rbusy[1]), 64'd0);
        checkOutput("pre_edge_port0", 64'(rdata[0 +: XLEN]), 64'hDEADBEEF);
        applyStimulus(1'b1, 5'd6, 32'h0000CAFE, 1'b0, 5'd0, 1'b0);
        checkOutput("post_edge_r6", 64'(rdata[XLEN +: XLEN]), 64'h0000CAFE);

        // Issue r7, then write it back.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
        setRead(5'd7, 5'd5);
        checkOutput("r7_busy", 64'(rbusy), 64'b01);
        checkOutput("r7_cnt", 64'(pending_cnt), 64'd1);
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0);
        checkOutput("r7_wb_busy", 64'(rbusy), 64'b00);
        checkOutput("r7_wb_cnt", 64'(pending_cnt), 64'd0);
        checkOutput("r7_wb_data", 64'(rdata[0 +: XLEN]), 64'hA5A5A5A5);

        // r3 pending, then write and reissue r3 on the same edge.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        checkOutput("r3_cnt_issue", 64'(pending_cnt), 64'd1);
        applyStimulus(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd3, 1'b0);
        setRead(5'd3, 5'd0);
        checkOutput("r3_still_busy", 64'(rbusy), 64'b01);
        checkOutput("r3_new_data", 64'(rdata[0 +: XLEN]), 64'h33333333);
        checkOutput("r3_cnt_same", 64'(pending_cnt), 64'd1);

        // Issue r1, r2, r4; then flush with an issue of r9.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
        checkOutput("pre_flush_cnt", 64'(pending_cnt), 64'd4);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1);
        checkOutput("flush_cnt", 64'(pending_cnt), 64'd1);
        setRead(5'd9, 5'd3);
        checkOutput("flush_r9_r3", 64'(rbusy), 64'b01);
        setRead(5'd1, 5'd4);
        checkOutput("flush_r1_r4", 64'(rbusy), 64'b00);

        // Write r9 and issue r10 on the same edge.
        applyStimulus(1'b1, 5'd9, 32'h99990000, 1'b1, 5'd10, 1'b0);
        setRead(5'd9, 5'd10);
        checkOutput("wr9_iss10_busy", 64'(rbusy), 64'b10);
        checkOutput("wr9_iss10_cnt", 64'(pending_cnt), 64'd1);
        checkOutput("wr9_data", 64'(rdata[0 +: XLEN]), 64'h99990000);

        // Write a non-pending register, reissue a pending one, issue r0.
        applyStimulus(1'b1, 5'd11, 32'h0B0B0B0B, 1'b0, 5'd0, 1'b0);
        setRead(5'd11, 5'd0);
        checkOutput("r11_not_busy", 64'(rbusy), 64'b00);
        checkOutput("r11_cnt", 64'(pending_cnt), 64'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0);
        checkOutput("reissue_cnt", 64'(pending_cnt), 64'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
        checkOutput("issue_r0_cnt", 64'(pending_cnt), 64'd1);
        checkOutput("issue_r0_busy", 64'(rbusy), 64'b00);

        // Build up more pending state, then reset mid-cycle.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b0);
        checkOutput("r31_cnt", 64'(pending_cnt), 64'd2);
        setRead(5'd10, 5'd31);
        checkOutput("r10_r31_busy", 64'(rbusy), 64'b11);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_cnt", 64'(pending_cnt), 64'd0);
        checkOutput("midreset_busy", 64'(rbusy), 64'b00);
        setRead(5'd5, 5'd6);
        checkOutput("midreset_r5", 64'(rdata[0 +: XLEN]), 64'h0);
        checkOutput("midreset_r6", 64'(rdata[XLEN +: XLEN]), 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        setRead(5'd10, 5'd5);
        checkOutput("post_reset_busy", 64'(rbusy), 64'b00);
        checkOutput("post_reset_r5", 64'(rdata[XLEN +: XLEN]), 64'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0);
        checkOutput("post_reset_issue_cnt", 64'(pending_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
